// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response channel plus APB4 completer bus for the bridge.
interface apb_master_bridge_if #(
  parameter int C_APB_ADDR_WIDTH = 12,
  parameter int C_APB_DATA_WIDTH = 32
);
  localparam int AW = C_APB_ADDR_WIDTH;
  localparam int DW = C_APB_DATA_WIDTH;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_addr;
  logic          i_cmd_write;
  logic [DW-1:0] i_cmd_wdata;
  logic [DW/8-1:0] i_cmd_wstrb;
  logic [2:0]    i_cmd_prot;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW/8-1:0] PWSTRB;
  logic [2:0]    PPROT;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata, i_cmd_wstrb, i_cmd_prot,
    input  i_rsp_ready, PREADY, PRDATA, PSLVERR,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
  );
  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata, i_cmd_wstrb, i_cmd_prot,
    output i_rsp_ready, PREADY, PRDATA, PSLVERR,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to single-outstanding APB4 transfer with ACCESS timeout.
module apb_master_bridge #(
  parameter int C_APB_ADDR_WIDTH = 12,
  parameter int C_APB_DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_bridge_if.master bus
);
  localparam int AW = C_APB_ADDR_WIDTH;
  localparam int DW = C_APB_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64)) begin : g_dw_check
    $error("apb_master_bridge: C_APB_DATA_WIDTH must be 8, 16, 32 or 64");
  end
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [SW-1:0] pwstrb_q, pwstrb_d;
  logic [2:0] pprot_q, pprot_d;
  logic accept, done, expire;
  assign accept = bus.i_cmd_valid && ready_q;
  assign done   = (state_q == ACCESS) && bus.PREADY;
  // PREADY in the expiry cycle takes priority over the timeout
  assign expire = (TIMEOUT != 0) && (state_q == ACCESS) && !bus.PREADY && (cnt_q == TO_LAST);
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      pwstrb_q    <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      pwstrb_q    <= pwstrb_d;
      pprot_q     <= pprot_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (done || expire) ? RESP : ACCESS;
      RESP:    state_d = bus.i_rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready_d     = state_d == IDLE;
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = state_d == ACCESS;
    rsp_valid_d = state_d == RESP;
    cnt_d       = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    paddr_d     = accept ? bus.i_cmd_addr : paddr_q;
    pwrite_d    = accept ? bus.i_cmd_write : pwrite_q;
    pwdata_d    = (accept && bus.i_cmd_write) ? bus.i_cmd_wdata : pwdata_q;
    pwstrb_d    = accept ? (bus.i_cmd_write ? bus.i_cmd_wstrb : '0) : pwstrb_q;
    pprot_d     = accept ? bus.i_cmd_prot : pprot_q;
    rdata_d     = done ? (pwrite_q ? '0 : bus.PRDATA) : expire ? '0 : rdata_q;
    err_d       = done ? bus.PSLVERR : expire ? 1'b1 : err_q;
  end
  assign bus.o_cmd_ready = ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWSTRB      = pwstrb_q;
  assign bus.PPROT       = pprot_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a wait-state/error/stuck APB completer model.
module tb_apb_master_bridge;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic [31:0] mem [16];
  logic [31:0] exp_mem [16];
  int wait_n = 0;
  bit stuck_n = 0;
  bit serr_n = 0;
  int setup_n = 0, access_n = 0, moved_n = 0, strb_bad_n = 0, acc = 0;
  bit rdy;
  logic [11:0] seen_addr;
  logic [2:0] seen_prot;
  logic [31:0] seen_wdata;

  apb_master_bridge_if #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32)) bus();

  apb_master_bridge #(.C_APB_ADDR_WIDTH(12), .C_APB_DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .PCLK(clk),
    .PRESET(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // completer model: answers on the negedge so the bridge samples at the next posedge
  initial begin
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE) begin
        access_n++;
        if (bus.PADDR != seen_addr) moved_n++;
        if (!bus.PWRITE && bus.PWSTRB != 0) strb_bad_n++;
        rdy = !stuck_n && acc >= wait_n;
        acc++;
        bus.PREADY = rdy;
        bus.PRDATA = mem[bus.PADDR[5:2]];
        bus.PSLVERR = rdy && serr_n;
        if (rdy && bus.PWRITE && !serr_n)
          for (int b = 0; b < 4; b++)
            if (bus.PWSTRB[b]) mem[bus.PADDR[5:2]][8*b +: 8] = bus.PWDATA[8*b +: 8];
      end else begin
        if (bus.PSEL) begin
          setup_n++;
          acc = 0;
          seen_addr = bus.PADDR;
          seen_prot = bus.PPROT;
          seen_wdata = bus.PWDATA;
          if (!bus.PWRITE && bus.PWSTRB != 0) strb_bad_n++;
        end
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        bus.PSLVERR = 1'b0;
      end
    end
  end

  task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input int waits, input bit stuck, input bit serr, input int bp);
    bit to;
    int acc_exp, lat, n, s0, a0, m0, b0;
    logic [31:0] er, held;
    logic [32:0] e;
    to = stuck || waits >= TMO;
    acc_exp = to ? TMO : waits + 1;
    er = (w || to) ? 32'h0 : exp_mem[a[5:2]];
    if (w && !to && !serr)
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    sb.push_back({to || serr, er});
    wait_n = waits; stuck_n = stuck; serr_n = serr;
    s0 = setup_n; a0 = access_n; m0 = moved_n; b0 = strb_bad_n;
    bus.i_rsp_ready = (bp == 0);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr = a;
    bus.i_cmd_write = w;
    bus.i_cmd_wdata = d;
    bus.i_cmd_wstrb = s;
    bus.i_cmd_prot = p;
    n = 0;
    while (!bus.o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_rsp_valid && lat < 40);
    chk("latency", lat, 2 + acc_exp);
    held = bus.o_rsp_rdata;
    for (int k = 0; k < bp; k++) begin
      chk("bp_valid", bus.o_rsp_valid, 1);
      chk("bp_rdata", bus.o_rsp_rdata, held);
      chk("bp_cmd_ready", bus.o_cmd_ready, 0);
      chk("bp_psel", bus.PSEL, 0);
      @(negedge clk);
    end
    bus.i_rsp_ready = 1'b1;
    e = sb.pop_front();
    chk("rsp_valid", bus.o_rsp_valid, 1);
    chk("rsp_psel", bus.PSEL, 0);
    chk("rsp_rdata", bus.o_rsp_rdata, e[31:0]);
    chk("rsp_err", bus.o_rsp_err, e[32]);
    @(negedge clk);
    chk("idle_after", {bus.o_rsp_valid, bus.o_cmd_ready}, 2'b01);
    chk("setup_cycles", setup_n - s0, 1);
    chk("access_cycles", access_n - a0, acc_exp);
    chk("paddr", seen_addr, a);
    chk("paddr_stable", moved_n - m0, 0);
    chk("pprot", seen_prot, p);
    if (w) chk("pwdata", seen_wdata, d);
    else chk("pwstrb_read", strb_bad_n - b0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'hA5A50000 | i;
      exp_mem[i] = 32'hA5A50000 | i;
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr = '0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_wdata = '0;
    bus.i_cmd_wstrb = '0;
    bus.i_cmd_prot = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_psel", {bus.PSEL, bus.PENABLE}, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_cmd_ready", bus.o_cmd_ready, 0);
    chk("rst_paddr", bus.PADDR, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.o_cmd_ready, 1);
    xfer(12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 3'd2, 0, 0, 0, 0);
    xfer(12'h010, 1'b0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0);
    xfer(12'h020, 1'b1, 32'h11223344, 4'hF, 3'd1, 3, 0, 1, 0);
    xfer(12'h020, 1'b0, 32'h0, 4'h0, 3'd5, 3, 0, 0, 0);
    xfer(12'h030, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1, 0, 0);
    xfer(12'h034, 1'b1, 32'hCAFEF00D, 4'hF, 3'd0, 0, 1, 0, 0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, 3'd7, 1, 0, 0, 5);
    xfer(12'h010, 1'b1, 32'h12345678, 4'b0011, 3'd3, 0, 0, 0, 0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0);
    // reset during a wait-stated read: the transfer must vanish without a response
    wait_n = 10; stuck_n = 0; serr_n = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr = 12'h010;
    bus.i_cmd_write = 1'b0;
    @(posedge clk);
    #1 bus.i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_penable", bus.PENABLE, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_psel", {bus.PSEL, bus.PENABLE}, 0);
    chk("mid_rst_rsp_valid", bus.o_rsp_valid, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_rsp_valid || bus.PSEL) n++;
    end
    chk("no_rsp_after_rst", n, 0);
    xfer(12'h010, 1'b0, 32'h0, 4'h0, 3'd0, 2, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      xfer(12'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(1, 15)), 3'($urandom_range(0, 7)), $urandom_range(0, 5), 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that converts a simple valid/ready command channel into APB4 transfers and returns the result on a valid/ready response channel.
- Drives one APB completer directly: its PSEL/PENABLE/PADDR/PWRITE/PWDATA/PWSTRB/PPROT feed the slave's inputs, and the slave's PREADY/PRDATA/PSLVERR come back.
- Single outstanding transfer.
- A programmable timeout terminates a hung ACCESS phase with an error.

Parameters:
- C_APB_ADDR_WIDTH, 12, APB address width (AW).
- C_APB_DATA_WIDTH, 32, APB data width (DW); must be 8, 16, 32 or 64.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before forced error completion; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_addr  in  AW  byte address.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_wdata  in  DW  write data.
- i_cmd_wstrb  in  DW/8  byte strobes; ignored for reads.
- i_cmd_prot  in  3  protection attributes.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when high with o_rsp_valid.
- o_rsp_rdata  out  DW  read data; 0 for writes and timeouts.
- o_rsp_err  out  1  PSLVERR or timeout.
- PSEL, PENABLE  out  1 each  APB select and enable.
- PADDR  out  AW  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DW  APB write data.
- PWSTRB  out  DW/8  APB write strobes.
- PPROT  out  3  APB protection.
- PREADY  in  1  completer ready.
- PRDATA  in  DW  completer read data.
- PSLVERR  in  1  completer error.

Behaviour:
- Clock/reset: one clock, PCLK. PRESET is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including o_cmd_ready. o_cmd_ready rises one cycle after PRESET deasserts.
- States: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid & o_cmd_ready: register addr, write, wdata, prot and wstrb into the APB outputs.
  - For reads, PWSTRB is forced to 0 and PWDATA keeps its previous value.
  - Next state SETUP.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0, o_cmd_ready = 0.
  - Next state ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE, PWDATA, PWSTRB and PPROT are held stable from SETUP through the end of ACCESS.
  - Timeout counter clears on entry and increments each ACCESS cycle with PREADY = 0.
  - PREADY = 1: capture PRDATA into o_rsp_rdata (reads only; writes give 0) and PSLVERR into o_rsp_err. Next state RESP.
  - Else, if TIMEOUT != 0 and this is the TIMEOUT-th ACCESS cycle: o_rsp_rdata = 0, o_rsp_err = 1. Next state RESP.
  - PREADY in the same cycle as timeout expiry: normal completion wins.
- RESP:
  - PSEL = 0, PENABLE = 0, o_rsp_valid = 1.
  - o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready.
  - On handshake: o_rsp_valid clears and state returns to IDLE.
- Timing:
  - Latency: command handshake at edge N → SETUP in cycle N+1 → ACCESS in N+2 → with zero-wait PREADY, o_rsp_valid in N+3.
  - Minimum 4 cycles per transfer.
  - o_cmd_ready is low in SETUP/ACCESS/RESP; there is no command acceptance in the same cycle as a response handshake.
- Outside a transfer, PADDR/PWRITE/PWDATA/PPROT hold their last values. PWSTRB holds its last value too; don't-care while PSEL = 0.
- Reset mid-transfer: PSEL/PENABLE drop at the reset edge, no response is produced, state goes to IDLE, and any pending response is discarded.
- Timeout counter width is $clog2(TIMEOUT+1). With TIMEOUT = 0 it is unused and ACCESS waits indefinitely.

Test Plan:
- Write, zero-wait completer: cmd addr=0x010, wdata=0xDEADBEEF, wstrb=4'hF
  → PSEL high in 2 cycles, PENABLE in the 2nd, PWDATA=0xDEADBEEF;
  → o_rsp_valid 3 cycles after accept, rdata=0, err=0.
- Read-back, completer model returning PRDATA=0xDEADBEEF for addr 0x010 → o_rsp_rdata=0xDEADBEEF, err=0, PWSTRB=0 during transfer.
- Wait states: PREADY low for 3 ACCESS cycles, PSLVERR=1 on completion
  → PENABLE high 4 cycles, PADDR stable throughout, err=1.
- Timeout, TIMEOUT=4, PREADY stuck low → exactly 4 ACCESS cycles, then PSEL=0, o_rsp_valid=1, err=1, rdata=0.
- Response backpressure: i_rsp_ready low 5 cycles → o_rsp_valid and rdata stable, o_cmd_ready=0 and PSEL=0 throughout; IDLE the cycle after handshake.
- Reset in ACCESS: PRESET high 1 cycle during a wait-stated read → PSEL/PENABLE/o_rsp_valid=0 next cycle, no response, next command completes normally.
